write_back_unit: RTL
====================

Name: write_back_unit

Overview:
- Parametrised successor to the pipeline write-back stage: final stage between MEM/WB pipeline register and register-file write port.
- Selects write-back source among four (ALU result, load data, PC+4, immediate); extracts, aligns and sign/zero-extends sub-word loads.
- Supports stall and flush; suppresses writes to x0; registers outputs for the register file; keeps a retired-instruction counter.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.
- REG_AW, 5, register address width.
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  incoming instruction in this stage is valid.
- stall  in  1  hold stage; no instruction retired this cycle.
- flush  in  1  kill incoming instruction.
- Result  in  XLEN  ALU result; also load address low bits source for offset.
- ReadData  in  XLEN  aligned word read from data memory.
- pc_plus4  in  XLEN  return address for JAL/JALR.
- imm  in  XLEN  immediate (LUI path).
- wb_sel  in  2  00=Result, 01=load, 10=pc_plus4, 11=imm.
- load_size  in  2  00=byte, 01=half, 10=word, 11=dword.
- load_unsigned  in  1  1=zero-extend, 0=sign-extend.
- rd_in  in  REG_AW  destination register.
- regWrite_receive  in  1  control bit from earlier stages.
- WriteData  out  XLEN  registered write-back data.
- rd_out  out  REG_AW  registered destination.
- regWrite  out  1  registered register-file write enable.
- retired_count  out  CNT_W  number of retired instructions.

Behaviour:
- Reset (rst=1 at clk edge): WriteData=0, rd_out=0, regWrite=0, retired_count=0. Reset overrides stall and flush and applies mid-operation.
- Latency: one cycle. Inputs sampled at edge N appear on outputs after edge N.
- Byte offset OFF = Result[log2(XLEN/8)-1:0].
- Load extraction uses ReadData shifted right by 8*OFF:
  - byte: bits[7:0]; half: bits[15:0] with OFF[0] ignored; word: bits[31:0] with OFF[1:0] ignored.
  - dword: full ReadData, OFF ignored.
  - Extended to XLEN by load_unsigned.
  - With XLEN=32, dword is treated as word.
  - Misaligned accesses are not trapped; low offset bits are ignored as stated.
- accept = valid_in & ~stall & ~flush.
- Priority: rst > flush > stall > normal.
- Normal (accept): WriteData=selected source, rd_out=rd_in, regWrite = regWrite_receive & (rd_in!=0), retired_count increments by 1 (wraps from all-ones to 0).
  - Instructions with regWrite_receive=0 (stores, branches) still count as retired.
- valid_in=0 with no stall/flush: regWrite=0; WriteData/rd_out hold; count unchanged.
- stall=1: regWrite=0 (no duplicate write); WriteData/rd_out hold; count unchanged.
- flush=1: regWrite=0; WriteData/rd_out hold; count unchanged; flush wins over simultaneous stall.
- Write to x0 (rd_in=0): WriteData and rd_out still update; regWrite=0.
- regWrite is a one-cycle pulse per accepted writing instruction; never asserted for two consecutive cycles unless two instructions are accepted back to back.

Test Plan:
- Reset: hold rst 2 cycles with valid_in=1 and stall=1 -> all outputs 0, retired_count=0.
- ALU path: wb_sel=00, Result=0x1234, rd_in=5, regWrite_receive=1, accept -> next cycle WriteData=0x1234, rd_out=5, regWrite=1, retired_count=1.
- Load extraction: wb_sel=01, ReadData=0x8877665544332211, Result low bits=3.
  - byte signed -> 0x0000000000000044.
  - Result low bits=7, byte signed -> 0xFFFFFFFFFFFFFF88; unsigned -> 0x88.
  - half, offset 6, signed -> 0xFFFFFFFFFFFF8877.
  - word, offset 4, unsigned -> 0x0000000088776655.
- x0 suppression: wb_sel=11, imm=0xABC000, rd_in=0, regWrite_receive=1 -> WriteData=0xABC000, regWrite=0, retired_count increments.
- Stall/flush: accept an instruction, then stall 3 cycles, then flush with stall=1 -> regWrite=1 only in the first cycle; WriteData held; count increments once.
- Counter wrap: CNT_W=4, retire 17 instructions -> retired_count=1.

Source files
------------

// File: rtl/write_back_unit_if.sv
// rtl/write_back_unit_if.sv - MEM/WB to register-file write-back bundle
interface write_back_unit_if #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              valid_in;
  logic              stall;
  logic              flush;
  logic [XLEN-1:0]   Result;
  logic [XLEN-1:0]   ReadData;
  logic [XLEN-1:0]   pc_plus4;
  logic [XLEN-1:0]   imm;
  logic [1:0]        wb_sel;
  logic [1:0]        load_size;
  logic              load_unsigned;
  logic [REG_AW-1:0] rd_in;
  logic              regWrite_receive;
  logic [XLEN-1:0]   WriteData;
  logic [REG_AW-1:0] rd_out;
  logic              regWrite;
  logic [CNT_W-1:0]  retired_count;

  modport master (
    output valid_in, stall, flush, Result, ReadData, pc_plus4, imm,
           wb_sel, load_size, load_unsigned, rd_in, regWrite_receive,
    input  WriteData, rd_out, regWrite, retired_count
  );

  modport slave (
    input  valid_in, stall, flush, Result, ReadData, pc_plus4, imm,
           wb_sel, load_size, load_unsigned, rd_in, regWrite_receive,
    output WriteData, rd_out, regWrite, retired_count
  );
endinterface

// File: rtl/write_back_unit.sv
// rtl/write_back_unit.sv - write-back source select, load extraction, retire counter
module write_back_unit #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input logic               clk,
  input logic               rst,
  write_back_unit_if.slave  wb
);
  localparam int OFF_W = $clog2(XLEN / 8);
  localparam logic [OFF_W-1:0] HALF_MASK = ~OFF_W'(1);
  localparam logic [OFF_W-1:0] WORD_MASK = ~OFF_W'(3);

  logic [OFF_W-1:0] off_eff;
  logic [XLEN-1:0]  shifted;
  logic [XLEN-1:0]  load_data;
  logic [XLEN-1:0]  wb_data;
  logic             accept;

  assign accept = wb.valid_in & ~wb.stall & ~wb.flush;

  // Low offset bits below the access size are ignored, so misaligned loads never trap.
  always_comb begin
    off_eff = wb.Result[OFF_W-1:0];
    case (wb.load_size)
      2'b01:   off_eff = wb.Result[OFF_W-1:0] & HALF_MASK;
      2'b10:   off_eff = wb.Result[OFF_W-1:0] & WORD_MASK;
      2'b11:   off_eff = (XLEN == 64) ? '0 : (wb.Result[OFF_W-1:0] & WORD_MASK);
      default: off_eff = wb.Result[OFF_W-1:0];
    endcase
  end

  assign shifted = wb.ReadData >> {off_eff, 3'b000};

  always_comb begin
    load_data = shifted;
    case (wb.load_size)
      2'b00: load_data = wb.load_unsigned ? XLEN'(shifted[7:0])
                                          : XLEN'($signed(shifted[7:0]));
      2'b01: load_data = wb.load_unsigned ? XLEN'(shifted[15:0])
                                          : XLEN'($signed(shifted[15:0]));
      2'b10: load_data = wb.load_unsigned ? XLEN'(shifted[31:0])
                                          : XLEN'($signed(shifted[31:0]));
      default: begin
        // A 32-bit datapath has no doubleword, so it degenerates to word.
        if (XLEN == 64) load_data = shifted;
        else            load_data = wb.load_unsigned ? XLEN'(shifted[31:0])
                                                     : XLEN'($signed(shifted[31:0]));
      end
    endcase
  end

  always_comb begin
    wb_data = wb.Result;
    case (wb.wb_sel)
      2'b00:   wb_data = wb.Result;
      2'b01:   wb_data = load_data;
      2'b10:   wb_data = wb.pc_plus4;
      default: wb_data = wb.imm;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb.WriteData     <= '0;
      wb.rd_out        <= '0;
      wb.regWrite      <= 1'b0;
      wb.retired_count <= '0;
    end else begin
      wb.regWrite <= 1'b0;
      if (accept) begin
        wb.WriteData     <= wb_data;
        wb.rd_out        <= wb.rd_in;
        wb.regWrite      <= wb.regWrite_receive & (wb.rd_in != '0);
        wb.retired_count <= wb.retired_count + CNT_W'(1);
      end
    end
  end
endmodule
